mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 4-to-1 buffered multiplexer.
- Four requesters (d1..d4 sources) compete for the shared mux output Q.
- The block grants one requester at a time and drives the mux select pair {I1,I0}.
- Each grant is bounded by a burst limit, so no requester can starve the others.

---
 rtl/mux4_rr_arbiter_pkg.sv | 21 ++
 rtl/mux4_rr_arbiter_if.sv | 25 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 32 +++
 rtl/mux4_rr_arbiter.sv | 91 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter that drives
// the select pair of the 4-to-1 buffered mux.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_D1 = 2'b00;
  localparam logic [1:0] SEL_D2 = 2'b01;
  localparam logic [1:0] SEL_D3 = 2'b10;
  localparam logic [1:0] SEL_D4 = 2'b11;

  localparam int REQ_N = 4;

  function automatic logic [REQ_N-1:0] idx_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between the requesters (master) and the arbiter (slave).
// Handshake: a requester holds req[k] high for as long as it wants the mux; it owns
// the mux output in every cycle where gnt[k] is high, and gnt is never multi-hot.
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [REQ_N-1:0] req;
  logic [REQ_N-1:0] gnt;
  logic             I0;
  logic             I1;
  logic             busy;
  logic [1:0]       ptr;
  state_t           st;

  modport master (
    output req,
    input  gnt, I0, I1, busy, ptr, st
  );

  modport slave (
    input  req,
    output gnt, I0, I1, busy, ptr, st
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotate-priority picker: first set bit of (req & ~excl) scanning
// upward from i_start with wrap-around.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] i_req,
  input  logic [1:0]       i_start,
  input  logic [REQ_N-1:0] i_excl,
  output logic             o_found,
  output logic [1:0]       o_idx
);

  logic [REQ_N-1:0] w_cand;
  logic [1:0]       w_k;

  assign w_cand = i_req & ~i_excl;

  // Scan farthest offset first so the nearest candidate to i_start wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    w_k     = i_start;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      w_k = i_start + 2'(i);
      if (w_cand[w_k]) begin
        o_found = 1'b1;
        o_idx   = w_k;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the 4-to-1 mux: one owner at a time, bounded by MAX_BURST
// cycles while others wait, with registered grant and select outputs.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
)(
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus
);

  localparam logic [7:0] BURST = 8'(MAX_BURST);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [7:0]       r_cnt;
  logic [REQ_N-1:0] r_gnt;
  logic [1:0]       r_sel;
  logic             r_busy;

  logic [REQ_N-1:0] w_excl;
  logic [1:0]       w_start;
  logic             w_found;
  logic [1:0]       w_idx;
  logic             w_own_req;

  // While granted, ptr is the owner; excluding it makes the picker yield the next
  // requester in rotation, so one picker serves both IDLE entry and handoff.
  assign w_excl    = (r_state == ST_GRANT) ? idx_onehot(r_ptr) : '0;
  assign w_start   = r_ptr + 2'd1;
  assign w_own_req = bus.req[r_ptr];

  rr_pick4 u_pick (
    .i_req   (bus.req),
    .i_start (w_start),
    .i_excl  (w_excl),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd3;
      r_cnt   <= 8'd0;
      r_gnt   <= '0;
      r_sel   <= SEL_D1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_ptr   <= w_idx;
            r_sel   <= w_idx;
            r_gnt   <= idx_onehot(w_idx);
            r_busy  <= 1'b1;
            r_cnt   <= 8'd1;
          end
        end
        ST_GRANT: begin
          if (w_own_req && (r_cnt < BURST)) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (w_found) begin
            r_ptr <= w_idx;
            r_sel <= w_idx;
            r_gnt <= idx_onehot(w_idx);
            r_cnt <= 8'd1;
          end else if (w_own_req) begin
            r_cnt <= 8'd1;
          end else begin
            // ptr and select keep the last owner so the mux output stays put.
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.I0   = r_sel[0];
  assign bus.I1   = r_sel[1];
  assign bus.busy = r_busy;
  assign bus.ptr  = r_ptr;
  assign bus.st   = r_state;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus randomized request traffic
// compared against a rule-level round-robin model.
module tb_mux4_rr_arbiter;
  import mux4_rr_arbiter_pkg::*;

  localparam int MB = 4;

  logic clk;
  logic rst;
  mux4_rr_arbiter_if bus();

  logic [3:0] d_vec;
  logic       q;
  assign q = d_vec[{bus.I1, bus.I0}];

  int total;
  int bad;

  // Reference model: owner (-1 = idle), last owner, burst count, select
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  mux4_rr_arbiter #(.MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic int pick(input logic [3:0] r, input int from, input int excl);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (from + i) % 4;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int k;
    if (m_owner < 0) begin
      k = pick(r, m_ptr, -1);
      if (k >= 0) begin
        m_owner = k; m_ptr = k; m_sel = k; m_cnt = 1;
      end
    end else if (r[m_owner]) begin
      if (m_cnt < MB) m_cnt++;
      else begin
        k = pick(r, m_ptr, m_owner);
        if (k >= 0) begin
          m_owner = k; m_ptr = k; m_sel = k;
        end
        m_cnt = 1;
      end
    end else begin
      k = pick(r, m_ptr, m_owner);
      if (k >= 0) begin
        m_owner = k; m_ptr = k; m_sel = k; m_cnt = 1;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  function automatic logic [3:0] m_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    model_reset();
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    total++;
    if ({bus.I1, bus.I0} !== SEL_D1) begin bad++; $display("FAIL reset_sel: got %b want 00", {bus.I1, bus.I0}); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++;
    if (bus.ptr !== 2'd3) begin bad++; $display("FAIL reset_ptr: got %0d want 3", bus.ptr); end
    total++;
    if (bus.st !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %b want IDLE", bus.st); end
    rst = 1'b0;
  endtask

  task automatic test_single_and_async_reset();
    do_reset();
    tick(4'b0001);
    total++;
    if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
    total++;
    if ({bus.I1, bus.I0} !== 2'b00) begin bad++; $display("FAIL single_sel: got %b want 00", {bus.I1, bus.I0}); end
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    total++;
    if (bus.ptr !== 2'd0) begin bad++; $display("FAIL single_ptr: got %0d want 0", bus.ptr); end
    tick(4'b0001);
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL async_reset: got gnt=%b busy=%b want gnt=0000 busy=0", bus.gnt, bus.busy);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_all_req();
    logic [3:0] exp_g;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick(4'b1111);
      exp_g = 4'(1 << ((c / 4) % 4));
      total++;
      if (bus.gnt !== exp_g || bus.busy !== 1'b1) begin
        bad++; $display("FAIL all_req_rotation c=%0d: got gnt=%b busy=%b want gnt=%b busy=1", c, bus.gnt, bus.busy, exp_g);
      end
      total++;
      if ({bus.I1, bus.I0} !== 2'((c / 4) % 4)) begin
        bad++; $display("FAIL all_req_sel c=%0d: got %b want %0d", c, {bus.I1, bus.I0}, (c / 4) % 4);
      end
    end
  endtask

  task automatic test_hold_alone();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(4'b0100);
      total++;
      if (bus.gnt !== 4'b0100 || {bus.I1, bus.I0} !== SEL_D3 || bus.st !== ST_GRANT) begin
        bad++; $display("FAIL hold_alone c=%0d: got gnt=%b sel=%b st=%b want gnt=0100 sel=10 st=GRANT",
                        c, bus.gnt, {bus.I1, bus.I0}, bus.st);
      end
    end
  endtask

  task automatic test_drop_handoff();
    do_reset();
    tick(4'b0010);
    tick(4'b1001);
    total++;
    if (bus.gnt !== 4'b1000 || {bus.I1, bus.I0} !== SEL_D4 || bus.ptr !== 2'd3) begin
      bad++; $display("FAIL drop_handoff: got gnt=%b sel=%b ptr=%0d want gnt=1000 sel=11 ptr=3",
                      bus.gnt, {bus.I1, bus.I0}, bus.ptr);
    end
  endtask

  task automatic test_release_idle();
    do_reset();
    tick(4'b0010);
    tick(4'b0000);
    total++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || {bus.I1, bus.I0} !== SEL_D2 || bus.ptr !== 2'd1) begin
      bad++; $display("FAIL release_idle: got gnt=%b busy=%b sel=%b ptr=%0d want gnt=0000 busy=0 sel=01 ptr=1",
                      bus.gnt, bus.busy, {bus.I1, bus.I0}, bus.ptr);
    end
    tick(4'b0011);
    total++;
    if (bus.gnt !== 4'b0001 || {bus.I1, bus.I0} !== SEL_D1) begin
      bad++; $display("FAIL reentry_rotation: got gnt=%b sel=%b want gnt=0001 sel=00", bus.gnt, {bus.I1, bus.I0});
    end
  endtask

  task automatic test_mux_integration();
    logic exp_q;
    d_vec = 4'b1010;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      tick(4'b1111);
      exp_q = ((c / 4) % 2) == 1;
      total++;
      if (q !== exp_q) begin bad++; $display("FAIL mux_q c=%0d: got %b want %b", c, q, exp_q); end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_q[$];
    logic [3:0] r;
    logic [3:0] eg;
    int hold;
    int waitc[4];
    int worst;
    do_reset();
    for (int k = 0; k < 4; k++) waitc[k] = 0;
    hold = 0;
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        r = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
        if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
      end
      if ($urandom_range(0, 150) == 0) begin
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
          bad++; $display("FAIL rand_async_reset c=%0d: got gnt=%b busy=%b want 0000/0", c, bus.gnt, bus.busy);
        end
        model_reset();
        for (int k = 0; k < 4; k++) waitc[k] = 0;
        @(negedge clk);
        rst = 1'b0;
      end
      tick(r);
      exp_q.push_back(m_gnt());
      eg = exp_q.pop_front();
      total++;
      if (bus.gnt !== eg || bus.busy !== (eg != 4'b0000) || {bus.I1, bus.I0} !== 2'(m_sel) || bus.ptr !== 2'(m_ptr)) begin
        bad++; $display("FAIL rand_model c=%0d req=%b: got gnt=%b busy=%b sel=%0d ptr=%0d want gnt=%b sel=%0d ptr=%0d",
                        c, r, bus.gnt, bus.busy, {bus.I1, bus.I0}, bus.ptr, eg, m_sel, m_ptr);
      end
      total++;
      if ($countones(bus.gnt) > 1) begin bad++; $display("FAIL rand_onehot c=%0d: got %b want at most one bit", c, bus.gnt); end
      worst = 0;
      for (int k = 0; k < 4; k++) begin
        if (r[k] && !bus.gnt[k]) waitc[k]++;
        else waitc[k] = 0;
        if (waitc[k] > worst) worst = waitc[k];
      end
      total++;
      if (worst > 3 * MB + 1) begin bad++; $display("FAIL rand_max_wait c=%0d: got %0d want <= %0d", c, worst, 3 * MB + 1); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad = 0;
    d_vec = 4'b0000;
    rst = 1'b1;
    bus.req = 4'b0000;
    model_reset();
    test_reset();
    test_single_and_async_reset();
    test_all_req();
    test_hold_alone();
    test_drop_handoff();
    test_release_idle();
    test_mux_integration();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
